// File: rtl/timer_pkg.sv
// timer_sched shared definitions: FSM state encoding and width limits.
package timer_pkg;

    localparam int unsigned TIMER_W   = 16;
    localparam int unsigned N_REQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_e;

endpackage : timer_pkg

// File: rtl/timer_sched_rr_arbiter.sv
// Round-robin arbiter for timer_sched: the first set request at or after the
// pointer (circularly) wins. Purely combinational; a pointer held at zero gives
// fixed lowest-index priority.
module rr_arbiter
    import timer_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]                                    i_req,
    input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]        i_ptr,
    output logic [N_REQ-1:0]                                    o_gnt_c,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]        o_idx_c
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_off;
    logic             w_found;
    logic [SUM_W-1:0] w_sum;

    // Rotate requests so the pointer sits at bit 0, pick the lowest set bit,
    // then rotate the offset back into an absolute index.
    always_comb begin
        w_rot   = N_REQ'({i_req, i_req} >> i_ptr);
        w_off   = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDX_W'(i);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= SUM_W'(N_REQ)) begin
            w_sum = w_sum - SUM_W'(N_REQ);
        end
        o_idx_c = IDX_W'(w_sum);
        o_gnt_c = w_found ? (N_REQ'(1) << o_idx_c) : '0;
    end

endmodule : rr_arbiter

// File: rtl/timer_sched.sv
// timer_sched: shares one free-running W-bit timer among N_REQ requesters.
// The owner gets a grant, the timer is enabled, its count is snapshotted as a
// base, and done pulses once (t_out - base) mod 2^W reaches the latched duration.
// Build option TIMER_SCHED_PRIO_EN: fixed lowest-index priority, no RR pointer.
module timer_sched
    import timer_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = TIMER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_dur,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [W-1:0]       elapsed,
    output logic               t_en,
    input  logic               t_valid,
    input  logic [W-1:0]       t_out
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    timer_state_e     r_state;
    timer_state_e     w_state_nxt;

    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_done,  w_done_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_t_en,  w_t_en_nxt;
    logic [W-1:0]     r_elapsed, w_elapsed_nxt;
    logic [W-1:0]     r_base,  w_base_nxt;
    logic [W-1:0]     r_dur,   w_dur_nxt;
    logic [IDX_W-1:0] r_idx,   w_idx_nxt;

    logic [IDX_W-1:0] w_ptr;
    logic [N_REQ-1:0] w_win_oh;
    logic [IDX_W-1:0] w_win_idx;
    logic [W-1:0]     w_win_dur;
    logic             w_own_req;
    logic [W-1:0]     w_diff;
    logic             w_release;

`ifdef TIMER_SCHED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    assign w_ptr = r_ptr;
`endif

    rr_arbiter #(
        .N_REQ   (N_REQ)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (w_ptr),
        .o_gnt_c (w_win_oh),
        .o_idx_c (w_win_idx)
    );

    // Modulo-2^W distance from the captured base; wrap is transparent.
    assign w_diff = t_out - r_base;

    // Duration slice of the arbitration winner and request level of the owner.
    always_comb begin
        w_win_dur = '0;
        w_own_req = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_win_dur = req_dur[i*int'(W) +: W];
            end
            if (r_idx == IDX_W'(i)) begin
                w_own_req = req[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; a dropped owner request beats expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req != '0) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (!w_own_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (t_valid) begin
                    w_state_nxt = (r_dur == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_own_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (t_valid && (w_diff >= r_dur)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs and job context.
    always_comb begin
        w_release     = 1'b0;
        w_grant_nxt   = r_grant;
        w_done_nxt    = '0;
        w_busy_nxt    = r_busy;
        w_t_en_nxt    = r_t_en;
        w_elapsed_nxt = r_elapsed;
        w_base_nxt    = r_base;
        w_dur_nxt     = r_dur;
        w_idx_nxt     = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (req != '0) begin
                    w_grant_nxt   = w_win_oh;
                    w_busy_nxt    = 1'b1;
                    w_t_en_nxt    = 1'b1;
                    w_idx_nxt     = w_win_idx;
                    w_dur_nxt     = w_win_dur;
                    w_elapsed_nxt = '0;
                end
            end
            ST_START: begin
                if (!w_own_req) begin
                    w_release = 1'b1;
                end else if (t_valid) begin
                    w_base_nxt = t_out;
                end
            end
            ST_RUN: begin
                if (!w_own_req) begin
                    w_release = 1'b1;
                end else if (t_valid) begin
                    w_elapsed_nxt = w_diff;
                end
            end
            ST_DONE: begin
                w_release  = 1'b1;
                w_done_nxt = r_grant;
            end
            default: begin
                w_release = 1'b1;
            end
        endcase
        if (w_release) begin
            w_grant_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_t_en_nxt  = 1'b0;
        end
`ifndef TIMER_SCHED_PRIO_EN
        w_ptr_nxt = r_ptr;
        if (w_release) begin
            w_ptr_nxt = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
        end
`endif
    end

    // Output and job-context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant   <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_t_en    <= 1'b0;
            r_elapsed <= '0;
            r_base    <= '0;
            r_dur     <= '0;
            r_idx     <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_t_en    <= w_t_en_nxt;
            r_elapsed <= w_elapsed_nxt;
            r_base    <= w_base_nxt;
            r_dur     <= w_dur_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

`ifndef TIMER_SCHED_PRIO_EN
    // Round-robin pointer: one past the owner after every completion or cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    assign grant   = r_grant;
    assign done    = r_done;
    assign busy    = r_busy;
    assign t_en    = r_t_en;
    assign elapsed = r_elapsed;

endmodule : timer_sched
